pwm_compare_sequencer: RTL and testbench

- Sits between the SPI register decoder and the PWM register file, and owns the single register write port.
- Arbitrates that port between host writes from SPI and an internal duty-sweep engine.
- The engine rewrites COMPARE1 (0x03 LSB, 0x04 MSB) once per counter period-wrap, giving triangle or sawtooth duty modulation without host traffic.
- The LSB/MSB pair is always written atomically, so the PWM never compares against a half-updated value.

---
 rtl/pwm_pkg.sv | 37 +++
 rtl/pwm_seq_step.sv | 58 +++++
 rtl/pwm_compare_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_pwm_compare_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM register map, sweep modes and sequencer state encoding
// Optional feature macro: PWM_SEQ_COMPARE2_EN (adds the COMPARE2 write states).
package pwm_pkg;

    // Register file map. Multi-byte registers occupy addr (LSB) and addr+1 (MSB).
    typedef enum logic [7:0] {
        REG_PERIOD        = 8'h00,
        REG_COUNTER_EN    = 8'h02,
        REG_COMPARE1      = 8'h03,
        REG_COMPARE2      = 8'h05,
        REG_COUNTER_RESET = 8'h07,
        REG_COUNTER_VAL   = 8'h08,
        REG_PRESCALE      = 8'h0A,
        REG_UPNOTDOWN     = 8'h0B,
        REG_PWM_EN        = 8'h0C,
        REG_FUNCTIONS     = 8'h0D
    } reg_addr_t;

    typedef enum logic {
        SEQ_TRIANGLE = 1'b0,
        SEQ_SAWTOOTH = 1'b1
    } seq_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CALC,
        ST_WR_LO,
        ST_WR_HI
`ifdef PWM_SEQ_COMPARE2_EN
        ,
        ST_WR2_LO,
        ST_WR2_HI
`endif
    } seq_state_t;

endpackage

// File: rtl/pwm_seq_step.sv
// rtl/pwm_seq_step.sv - combinational next-duty / direction calculator for the sweep engine
// Ports:
//   duty, dir_up        current duty value and triangle direction (1 = up)
//   mode                SEQ_TRIANGLE / SEQ_SAWTOOTH
//   seq_lo/hi/step      sweep bounds and increment
//   next_duty/dir_up    value and direction for the next period
module pwm_seq_step
    import pwm_pkg::*;
#(
    parameter int CMP_W = 16
) (
    input  logic [CMP_W-1:0] duty,
    input  logic             dir_up,
    input  logic             mode,
    input  logic [CMP_W-1:0] seq_lo,
    input  logic [CMP_W-1:0] seq_hi,
    input  logic [CMP_W-1:0] seq_step,
    output logic [CMP_W-1:0] next_duty,
    output logic             next_dir_up
);

    // One extra bit so neither sum can wrap around and look small.
    logic [CMP_W:0] up_sum;
    logic [CMP_W:0] lo_plus_step;

    assign up_sum       = {1'b0, duty}   + {1'b0, seq_step};
    assign lo_plus_step = {1'b0, seq_lo} + {1'b0, seq_step};

    always_comb begin
        next_duty   = duty;
        next_dir_up = dir_up;
        if ((seq_step == '0) || (seq_lo >= seq_hi)) begin
            // Degenerate sweep: park on the lower bound.
            next_duty = seq_lo;
        end else if (mode == SEQ_SAWTOOTH) begin
            if (up_sum > {1'b0, seq_hi}) begin
                next_duty = seq_lo;
            end else begin
                next_duty = up_sum[CMP_W-1:0];
            end
        end else if (dir_up) begin
            if (up_sum >= {1'b0, seq_hi}) begin
                next_duty   = seq_hi;
                next_dir_up = 1'b0;
            end else begin
                next_duty = up_sum[CMP_W-1:0];
            end
        end else begin
            if ({1'b0, duty} <= lo_plus_step) begin
                next_duty   = seq_lo;
                next_dir_up = 1'b1;
            end else begin
                next_duty = duty - seq_step;
            end
        end
    end

endmodule

// File: rtl/pwm_compare_sequencer.sv
// rtl/pwm_compare_sequencer.sv - register write-port arbiter with per-wrap COMPARE1 duty sweep
// Optional feature macro: PWM_SEQ_COMPARE2_EN (adds seq_width input and COMPARE2 window writes).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   host_wr/addr/wdata, host_ack  host write request (held until ack), ack pulse on acceptance
//   seq_start, seq_stop           sweep start / stop pulses
//   seq_mode, seq_lo/hi/step      sweep shape: 0 triangle, 1 sawtooth; bounds; increment
//   period_wrap                   counter wrap pulse, one duty update per wrap
//   bus_wr/addr/wdata             registered register-file write port
//   seq_busy, cur_duty            engine not idle; last duty fully written (LSB+MSB)
module pwm_compare_sequencer
    import pwm_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int CMP_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    input  logic              seq_start,
    input  logic              seq_stop,
    input  logic              seq_mode,
    input  logic [CMP_W-1:0]  seq_lo,
    input  logic [CMP_W-1:0]  seq_hi,
    input  logic [CMP_W-1:0]  seq_step,
`ifdef PWM_SEQ_COMPARE2_EN
    input  logic [CMP_W-1:0]  seq_width,
`endif
    input  logic              period_wrap,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              seq_busy,
    output logic [CMP_W-1:0]  cur_duty
);

    seq_state_t        state;
    logic [CMP_W-1:0]  duty;
    logic              dir_up;
    logic              wrap_pend;
    logic              stop_pend;

    logic [CMP_W-1:0]  next_duty;
    logic              next_dir_up;

    logic              host_blocked;
    logic              host_grant;
    logic              eng_issue;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_data;

    pwm_seq_step #(
        .CMP_W(CMP_W)
    ) u_step (
        .duty       (duty),
        .dir_up     (dir_up),
        .mode       (seq_mode),
        .seq_lo     (seq_lo),
        .seq_hi     (seq_hi),
        .seq_step   (seq_step),
        .next_duty  (next_duty),
        .next_dir_up(next_dir_up)
    );

`ifdef PWM_SEQ_COMPARE2_EN
    // Upper edge of the moving window, clamped to the sweep ceiling.
    logic [CMP_W:0]   cmp2_sum;
    logic [CMP_W-1:0] cmp2_val;

    assign cmp2_sum = {1'b0, duty} + {1'b0, seq_width};
    assign cmp2_val = (cmp2_sum > {1'b0, seq_hi}) ? seq_hi : cmp2_sum[CMP_W-1:0];
`endif

    // Once the LSB has gone out the rest of the group may not be split by the host.
    always_comb begin
        host_blocked = (state == ST_WR_HI);
`ifdef PWM_SEQ_COMPARE2_EN
        host_blocked = host_blocked || (state == ST_WR2_LO) || (state == ST_WR2_HI);
`endif
    end

    assign host_grant = host_wr && !host_blocked;
    assign host_ack   = host_grant && !rst;
    assign seq_busy   = (state != ST_IDLE);

    always_comb begin
        eng_issue = 1'b0;
        eng_addr  = '0;
        eng_data  = '0;
        case (state)
            ST_WR_LO: begin
                // The host has priority here; the pair only starts on a free cycle.
                eng_issue = !host_wr;
                eng_addr  = ADDR_W'(REG_COMPARE1);
                eng_data  = duty[DATA_W-1:0];
            end
            ST_WR_HI: begin
                eng_issue = 1'b1;
                eng_addr  = ADDR_W'(REG_COMPARE1) + ADDR_W'(1);
                eng_data  = duty[CMP_W-1 -: DATA_W];
            end
`ifdef PWM_SEQ_COMPARE2_EN
            ST_WR2_LO: begin
                eng_issue = 1'b1;
                eng_addr  = ADDR_W'(REG_COMPARE2);
                eng_data  = cmp2_val[DATA_W-1:0];
            end
            ST_WR2_HI: begin
                eng_issue = 1'b1;
                eng_addr  = ADDR_W'(REG_COMPARE2) + ADDR_W'(1);
                eng_data  = cmp2_val[CMP_W-1 -: DATA_W];
            end
`endif
            default: begin
                eng_issue = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            duty      <= '0;
            dir_up    <= 1'b1;
            wrap_pend <= 1'b0;
            stop_pend <= 1'b0;
            cur_duty  <= '0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            bus_wr <= host_grant || eng_issue;
            if (host_grant) begin
                bus_addr  <= host_addr;
                bus_wdata <= host_wdata;
            end else if (eng_issue) begin
                bus_addr  <= eng_addr;
                bus_wdata <= eng_data;
            end else begin
                bus_addr  <= '0;
                bus_wdata <= '0;
            end

            // Wraps seen while busy collapse into a single deferred update.
            if (period_wrap && (state != ST_IDLE) && (state != ST_WAIT)) begin
                wrap_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (seq_start && !seq_stop) begin
                        duty      <= seq_lo;
                        dir_up    <= 1'b1;
                        wrap_pend <= 1'b0;
                        stop_pend <= 1'b0;
                        state     <= ST_WR_LO;
                    end
                end
                ST_WAIT: begin
                    if (seq_stop) begin
                        wrap_pend <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (period_wrap || wrap_pend) begin
                        wrap_pend <= 1'b0;
                        state     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (seq_stop) begin
                        wrap_pend <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        duty   <= next_duty;
                        dir_up <= next_dir_up;
                        state  <= ST_WR_LO;
                    end
                end
                ST_WR_LO: begin
                    // A stop here is remembered so the pair still completes.
                    if (seq_stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (!host_wr) begin
                        state <= ST_WR_HI;
                    end
                end
                ST_WR_HI: begin
                    cur_duty <= duty;
`ifdef PWM_SEQ_COMPARE2_EN
                    if (seq_stop) begin
                        stop_pend <= 1'b1;
                    end
                    state <= ST_WR2_LO;
`else
                    if (stop_pend || seq_stop) begin
                        stop_pend <= 1'b0;
                        wrap_pend <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT;
                    end
`endif
                end
`ifdef PWM_SEQ_COMPARE2_EN
                ST_WR2_LO: begin
                    if (seq_stop) begin
                        stop_pend <= 1'b1;
                    end
                    state <= ST_WR2_HI;
                end
                ST_WR2_HI: begin
                    if (stop_pend || seq_stop) begin
                        stop_pend <= 1'b0;
                        wrap_pend <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_compare_sequencer.sv
// tb/tb_pwm_compare_sequencer.sv - scoreboard bench for pwm_compare_sequencer
module tb_pwm_compare_sequencer;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int CMP_W  = 16;
`ifdef PWM_SEQ_COMPARE2_EN
    localparam int STALL_EXP = 3;
`else
    localparam int STALL_EXP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              host_wr = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_ack;
    logic              seq_start = 1'b0;
    logic              seq_stop = 1'b0;
    logic              seq_mode = 1'b0;
    logic [CMP_W-1:0]  seq_lo = '0;
    logic [CMP_W-1:0]  seq_hi = '0;
    logic [CMP_W-1:0]  seq_step = '0;
`ifdef PWM_SEQ_COMPARE2_EN
    logic [CMP_W-1:0]  seq_width = 16'd3;
`endif
    logic              period_wrap = 1'b0;
    logic              bus_wr;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              seq_busy;
    logic [CMP_W-1:0]  cur_duty;

    pwm_compare_sequencer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CMP_W (CMP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .seq_start  (seq_start),
        .seq_stop   (seq_stop),
        .seq_mode   (seq_mode),
        .seq_lo     (seq_lo),
        .seq_hi     (seq_hi),
        .seq_step   (seq_step),
`ifdef PWM_SEQ_COMPARE2_EN
        .seq_width  (seq_width),
`endif
        .period_wrap(period_wrap),
        .bus_wr     (bus_wr),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .seq_busy   (seq_busy),
        .cur_duty   (cur_duty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               exp_q[$];
    int                n_tests = 0;
    int                n_fail = 0;
    int                cyc = 0;
    int                last_wr_cyc = -10;
    logic [ADDR_W-1:0] last_wr_addr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input int addr, input int data);
        wr_t w;
        w.addr = ADDR_W'(addr);
        w.data = DATA_W'(data);
        exp_q.push_back(w);
    endtask

    // Expected bus traffic for one engine update of duty value d.
    task automatic push_pair(input int d);
        push_wr(3, d & 'hff);
        push_wr(4, (d >> 8) & 'hff);
`ifdef PWM_SEQ_COMPARE2_EN
        begin
            int c2;
            c2 = d + int'(seq_width);
            if (c2 > int'(seq_hi)) c2 = int'(seq_hi);
            push_wr(5, c2 & 'hff);
            push_wr(6, (c2 >> 8) & 'hff);
        end
`endif
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: every write must match the head of the scoreboard, and
    // every MSB write must directly follow its LSB write.
    always @(negedge clk) begin
        if (!rst && bus_wr) begin
            if (exp_q.size() == 0) begin
                check("spurious_wr", 32'(bus_wr), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus_addr), 32'(e.addr));
                check("wr_data", 32'(bus_wdata), 32'(e.data));
                if (bus_addr == 6'h04 || bus_addr == 6'h06) begin
                    check("pair_gap", 32'(cyc - last_wr_cyc), 32'd1);
                    check("pair_order", 32'(last_wr_addr), 32'(bus_addr - 6'd1));
                end
            end
            last_wr_cyc  = cyc;
            last_wr_addr = bus_addr;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic start_seq();
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
    endtask

    task automatic stop_seq();
        seq_stop = 1'b1;
        tick();
        seq_stop = 1'b0;
        tick();
    endtask

    task automatic wrap();
        period_wrap = 1'b1;
        tick();
        period_wrap = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input int vals[]);
        push_pair(vals[0]);
        start_seq();
        wait_drain(tag);
        check({tag, "_duty0"}, 32'(cur_duty), 32'(vals[0]));
        for (int i = 1; i < vals.size(); i++) begin
            push_pair(vals[i]);
            wrap();
            wait_drain(tag);
            check($sformatf("%s_duty%0d", tag, i), 32'(cur_duty), 32'(vals[i]));
        end
        stop_seq();
        check({tag, "_idle"}, 32'(seq_busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int tri_vals[];
        int saw_vals[];
        int zero_vals[];
        int stall;

        // Reset: all outputs low, host_ack gated even with a request pending.
        rst     = 1'b1;
        host_wr = 1'b1;
        tick(); tick(); tick();
        check("rst_bus_wr", 32'(bus_wr), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
        check("rst_busy", 32'(seq_busy), 32'd0);
        check("rst_cur_duty", 32'(cur_duty), 32'd0);
        check("rst_host_ack", 32'(host_ack), 32'd0);
        host_wr = 1'b0;
        rst     = 1'b0;
        tick();

        // Triangle 2..6 step 2.
        seq_mode = 1'b0; seq_lo = 16'd2; seq_hi = 16'd6; seq_step = 16'd2;
        tri_vals = '{2, 4, 6, 4, 2, 4};
        run_sweep("tri", tri_vals);

        // Sawtooth 0..5 step 2, then step 0.
        seq_mode = 1'b1; seq_lo = 16'd0; seq_hi = 16'd5; seq_step = 16'd2;
        saw_vals = '{0, 2, 4, 0, 2};
        run_sweep("saw", saw_vals);
        seq_step = 16'd0;
        zero_vals = '{0, 0, 0};
        run_sweep("step0", zero_vals);

        // Start and stop together in IDLE: stop wins.
        seq_start = 1'b1; seq_stop = 1'b1;
        tick();
        seq_start = 1'b0; seq_stop = 1'b0;
        tick(); tick();
        check("start_stop_idle", 32'(seq_busy), 32'd0);

        // Host arbitration against a running triangle.
        seq_mode = 1'b0; seq_lo = 16'd2; seq_hi = 16'd6; seq_step = 16'd2;
        push_pair(2);
        start_seq();
        wait_drain("arb_start");

        // Host request in the WR_LO cycle goes first, then the pair.
        wrap();
        tick();
        push_wr('h0C, 'h01);
        push_pair(4);
        host_wr = 1'b1; host_addr = 6'h0C; host_wdata = 8'h01;
        #1;
        check("ack_in_wr_lo", 32'(host_ack), 32'd1);
        tick();
        host_wr = 1'b0;
        wait_drain("host_wr_lo");
        check("host_wr_lo_duty", 32'(cur_duty), 32'd4);

        // Host request raised in WR_HI stalls until the group completes.
        push_pair(6);
        push_wr('h0C, 'h02);
        wrap();
        tick();
        tick();
        host_wr = 1'b1; host_addr = 6'h0C; host_wdata = 8'h02;
        #1;
        stall = 0;
        while (!host_ack && stall < 10) begin
            tick();
            stall++;
        end
        check("host_stall", 32'(stall), 32'(STALL_EXP));
        tick();
        host_wr = 1'b0;
        wait_drain("host_wr_hi");
        check("host_wr_hi_duty", 32'(cur_duty), 32'd6);

        // Two wraps while busy collapse into exactly one extra update.
        push_wr('h0C, 'h03);
        push_pair(4);
        push_pair(2);
        wrap();
        tick();
        host_wr = 1'b1; host_addr = 6'h0C; host_wdata = 8'h03;
        period_wrap = 1'b1;
        tick();
        host_wr = 1'b0;
        period_wrap = 1'b0;
        tick();
        period_wrap = 1'b1;
        tick();
        period_wrap = 1'b0;
        wait_drain("wrap_pend");
        for (int i = 0; i < 12; i++) tick();
        check("wrap_pend_duty", 32'(cur_duty), 32'd2);

        // Stop in WR_LO: the pair still completes, then idle.
        push_pair(4);
        wrap();
        tick();
        seq_stop = 1'b1;
        tick();
        seq_stop = 1'b0;
        wait_drain("stop_wr_lo");
        check("stop_wr_lo_duty", 32'(cur_duty), 32'd4);
        tick();
        check("stop_wr_lo_idle", 32'(seq_busy), 32'd0);
        wrap();
        for (int i = 0; i < 6; i++) tick();
        check("idle_wrap_busy", 32'(seq_busy), 32'd0);

        // Reset between LSB and MSB: MSB never appears.
        seq_lo = 16'h0123; seq_hi = 16'h0200; seq_step = 16'd1;
        push_wr(3, 'h23);
        start_seq();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_bus_wr", 32'(bus_wr), 32'd0);
        check("midrst_bus_addr", 32'(bus_addr), 32'd0);
        check("midrst_bus_wdata", 32'(bus_wdata), 32'd0);
        check("midrst_busy", 32'(seq_busy), 32'd0);
        check("midrst_cur_duty", 32'(cur_duty), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("midrst_lsb_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Byte split of a 16-bit lower bound.
        push_pair('h0123);
        start_seq();
        wait_drain("split");
        check("split_duty", 32'(cur_duty), 32'h0123);
        stop_seq();
        check("split_idle", 32'(seq_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
